// File: rtl/fib_pkg.sv
// Shared definitions for the fibonacci handshake bridge: FSM encoding and
// the small-index results that are answered locally without the fibonacci unit.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    REQ     = 3'd2,
    RELEASE = 3'd3,
    DRAIN   = 3'd4,
    OUT     = 3'd5
  } state_t;

  // Indices below this value bypass the fibonacci unit.
  localparam int BYPASS_LIMIT = 3;

  function automatic logic [1:0] fib_bypass(input logic [1:0] n);
    case (n)
      2'd0:    fib_bypass = 2'd0;
      2'd1:    fib_bypass = 2'd1;
      2'd2:    fib_bypass = 2'd1;
      default: fib_bypass = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous bit.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/fib_handshake_bridge.sv
// Bridges a valid/ready request/response stream onto the four-phase req/fin
// handshake of an asynchronous fibonacci unit, with per-phase timeout.
module fib_handshake_bridge
  import fib_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  output logic             fib_req,
  output logic [WIDTH-1:0] fib_n,
  input  logic             fib_fin,
  input  logic [WIDTH-1:0] fib_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_error,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds its data stable until that transfer.

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_next;
  logic [CW-1:0]   tmo_cnt;
  logic            fin_s;
  logic            tmo_hit;

  logic            load_n, load_bypass, capture, finish_ok, finish_err;
  logic            req_set, req_clr, cnt_clr, cnt_run;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_fin_sync (
    .clk (clk),
    .rst (rst),
    .d   (fib_fin),
    .q   (fin_s)
  );

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_n      = 1'b0;
    load_bypass = 1'b0;
    capture     = 1'b0;
    finish_ok   = 1'b0;
    finish_err  = 1'b0;
    req_set     = 1'b0;
    req_clr     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_run     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_n < WIDTH'(BYPASS_LIMIT)) begin
            load_bypass = 1'b1;
            state_next  = OUT;
          end else begin
            load_n     = 1'b1;
            state_next = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        // fib_req is registered, so it rises one cycle after fib_n settled.
        req_set    = 1'b1;
        cnt_clr    = 1'b1;
        state_next = REQ;
      end
      REQ: begin
        cnt_run = 1'b1;
        if (fin_s) begin
          capture    = 1'b1;
          req_clr    = 1'b1;
          cnt_clr    = 1'b1;
          state_next = RELEASE;
        end else if (tmo_hit) begin
          req_clr    = 1'b1;
          state_next = DRAIN;
        end
      end
      RELEASE: begin
        cnt_run = 1'b1;
        if (!fin_s) begin
          finish_ok  = 1'b1;
          state_next = OUT;
        end else if (tmo_hit) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!fin_s) begin
          finish_err = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fib_req    <= 1'b0;
      fib_n      <= '0;
      out_result <= '0;
      out_error  <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      if (load_n) begin
        fib_n <= in_n;
      end
      if (req_set) begin
        fib_req <= 1'b1;
      end else if (req_clr) begin
        fib_req <= 1'b0;
      end
      if (load_bypass) begin
        out_result <= WIDTH'(fib_bypass(in_n[1:0]));
        out_error  <= 1'b0;
      end else if (capture) begin
        out_result <= fib_result;
      end else if (finish_ok) begin
        out_error <= 1'b0;
      end else if (finish_err) begin
        out_result <= '0;
        out_error  <= 1'b1;
      end
      if (cnt_clr) begin
        tmo_cnt <= '0;
      end else if (cnt_run && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fib_handshake_bridge.sv
// Directed bench for fib_handshake_bridge with a behavioural asynchronous
// fibonacci unit on the req/fin side.
module tb_fib_handshake_bridge;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_n;
  logic             fib_req;
  logic [WIDTH-1:0] fib_n;
  logic             fib_fin;
  logic [WIDTH-1:0] fib_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_error;
  logic             busy;

  int  pass_cnt;
  int  total_cnt;
  int  req_pulses;
  bit  model_en;
  time t_rise, t_fall;

  fib_handshake_bridge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .TIMEOUT     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_n       (in_n),
    .fib_req    (fib_req),
    .fib_n      (fib_n),
    .fib_fin    (fib_fin),
    .fib_result (fib_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error),
    .busy       (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WIDTH-1:0] fib_calc(input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] a, b, t;
    a = '0;
    b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // behavioural fibonacci unit: fin 7 ns after req rises, drops 5 ns after req falls
  initial begin
    fib_fin    = 1'b0;
    fib_result = '0;
    forever begin
      @(posedge fib_req);
      if (model_en) begin
        #7;
        if (fib_req) begin
          fib_result = fib_calc(fib_n);
          fib_fin    = 1'b1;
          if (fib_req) @(negedge fib_req);
          #5;
          fib_fin = 1'b0;
        end
      end
    end
  end

  always @(posedge fib_req) begin
    req_pulses = req_pulses + 1;
    t_rise     = $time;
  end
  always @(negedge fib_req) t_fall = $time;

  // scoreboard check
  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // driver tasks
  task automatic send(input logic [WIDTH-1:0] n);
    @(negedge clk);
    in_n     = n;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, out_valid}, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int p0;
    int k;
    pass_cnt   = 0;
    total_cnt  = 0;
    req_pulses = 0;
    model_en   = 1'b1;
    t_rise     = 0;
    t_fall     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_n       = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_in_ready",   {31'd0, in_ready},  1);
    check("rst_fib_req",    {31'd0, fib_req},   0);
    check("rst_out_valid",  {31'd0, out_valid}, 0);
    check("rst_busy",       {31'd0, busy},      0);
    check("rst_out_result", out_result,         0);
    check("rst_out_error",  {31'd0, out_error}, 0);
    check("rst_fib_n",      fib_n,              0);

    // bypass: result valid the cycle after acceptance, no request
    p0 = req_pulses;
    send(2);
    @(negedge clk);
    check("byp2_valid",  {31'd0, out_valid}, 1);
    check("byp2_result", out_result,         1);
    check("byp2_error",  {31'd0, out_error}, 0);
    check("byp2_ready",  {31'd0, in_ready},  0);
    consume();
    send(0);
    @(negedge clk);
    check("byp0_valid",  {31'd0, out_valid}, 1);
    check("byp0_result", out_result,         0);
    consume();
    send(1);
    @(negedge clk);
    check("byp1_result", out_result, 1);
    consume();
    check("byp_no_req", req_pulses - p0, 0);

    // normal path
    p0 = req_pulses;
    send(10);
    wait_out("n10_wait");
    check("n10_result", out_result,         55);
    check("n10_error",  {31'd0, out_error}, 0);
    check("n10_pulses", req_pulses - p0,    1);
    check("n10_fib_n",  fib_n,              10);
    check("n10_req_lo", {31'd0, fib_req},   0);
    consume();
    check("n10_idle", {31'd0, in_ready}, 1);

    // timeout: fin never rises
    model_en = 1'b0;
    send(5);
    wait_out("tmo_wait");
    check("tmo_req_width", 32'(t_fall - t_rise), 160);
    check("tmo_error",     {31'd0, out_error},   1);
    check("tmo_result",    out_result,           0);
    consume();
    model_en = 1'b1;

    // backpressure with a competing request held on the input
    send(20);
    wait_out("bp_wait");
    in_n     = 7;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid",  {31'd0, out_valid}, 1);
      check("bp_result", out_result,         6765);
      check("bp_ready",  {31'd0, in_ready},  0);
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    check("bp_released", {31'd0, out_valid}, 0);
    check("bp_idle",     {31'd0, in_ready},  1);

    // reset in the middle of a handshake
    send(10);
    k = 0;
    while (!fib_req && k < 100) begin
      #1;
      k++;
    end
    check("mid_req_seen", {31'd0, fib_req}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_req_drop", {31'd0, fib_req},   0);
    check("mid_valid",    {31'd0, out_valid}, 0);
    check("mid_busy",     {31'd0, busy},      0);
    check("mid_fib_n",    fib_n,              0);
    @(negedge clk);
    rst = 1'b0;
    #20;
    send(3);
    wait_out("post_rst_wait");
    check("post_rst_result", out_result,         2);
    check("post_rst_error",  {31'd0, out_error}, 0);
    consume();

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fib_handshake_bridge.md
FIB_HANDSHAKE_BRIDGE -- requirements
Module: fib_handshake_bridge

Interface
REQ-001 Parameter WIDTH, default 32: bit width of N and result, identical to the attached fibonacci unit.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages on fib_fin, minimum 2.
REQ-003 Parameter TIMEOUT, default 1024: cycles allowed per handshake phase, minimum 4.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  request N present.
REQ-007 in_ready  out  1  bridge accepts N this cycle.
REQ-008 in_n  in  WIDTH  requested index, numbered from 0.
REQ-009 fib_req  out  1  four-phase request to the fibonacci unit.
REQ-010 fib_n  out  WIDTH  N to the fibonacci unit (bundled data).
REQ-011 fib_fin  in  1  asynchronous completion from the fibonacci unit.
REQ-012 fib_result  in  WIDTH  fibonacci unit result, valid while fib_fin high.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_result  out  WIDTH  fibonacci(N) mod 2^WIDTH; 0 on error.
REQ-016 out_error  out  1  qualifies out_valid; handshake timed out.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, REQ, RELEASE, DRAIN, OUT.
REQ-019 IDLE: in_ready=1; on in_valid with in_n<3, load out_result (0->0, 1->1, 2->1), out_error=0, go to OUT; fib_req never asserts.
REQ-020 IDLE: on in_valid with in_n>=3, register fib_n=in_n, go to LAUNCH; fib_req stays 0 this cycle so fib_n is stable one full cycle before fib_req rises.
REQ-021 LAUNCH: assert fib_req, clear the timeout counter, go to REQ.
REQ-022 REQ: hold fib_req=1; when synchronized fin is 1, capture fib_result into out_result, drop fib_req, go to RELEASE.
REQ-023 RELEASE: fib_req=0; when synchronized fin is 0, set out_error=0, go to OUT.
REQ-024 OUT: out_valid=1 with out_result/out_error held stable; on out_ready go to IDLE; out_valid and in_ready are never high together.
REQ-025 fib_n SHALL remain constant from LAUNCH until the FSM returns to IDLE.
REQ-026 fib_fin SHALL pass only through the SYNC_STAGES synchronizer; fib_result is sampled only in the cycle the synchronized fin is first seen high.
REQ-027 Timeout: the counter runs in REQ and RELEASE and clears on each state entry; on reaching TIMEOUT in REQ, drop fib_req and go to DRAIN; on reaching TIMEOUT in RELEASE, go to DRAIN.
REQ-028 DRAIN: fib_req=0, no timeout; when synchronized fin is 0, set out_result=0, out_error=1, go to OUT.
REQ-029 Latency: bypass gives out_valid in the cycle after acceptance; the normal path takes 2 cycles after acceptance plus both synchronized handshake phases.
REQ-030 in_valid during any non-IDLE state SHALL be ignored (not accepted).

Reset
REQ-031 On rst: state=IDLE, fib_req=0, fib_n=0, out_valid=0, out_result=0, out_error=0, busy=0, synchronizer and counter=0; in_ready=1 after release.
REQ-032 Reset mid-handshake SHALL drop fib_req immediately; the next REQ phase waits for fin low via RELEASE/DRAIN rules only after a new acceptance (no special recovery).

Structure
REQ-033 State encoding and the bypass constants (fib(0..2)) SHALL live in a shared package fib_pkg.
REQ-034 The fin synchronizer SHALL be a sub-module sync_ff (parameterised depth, asynchronous active-high reset).

Verification
REQ-035 in_n=10, behavioural fibonacci model (fin 7 ns after req, drops 5 ns after req falls) -> out_result=55, out_error=0, fib_req exactly one pulse.
REQ-036 in_n=2 -> out_valid the next cycle, out_result=1, fib_req stays 0; in_n=0 -> out_result=0.
REQ-037 TIMEOUT=16, fib_fin tied 0, in_n=5 -> fib_req falls 16 cycles after rising, out_valid with out_error=1, out_result=0.
REQ-038 in_n=20, out_ready held 0 for 10 cycles -> out_valid and out_result=6765 stable, in_ready=0 throughout, accepted on out_ready.
REQ-039 rst asserted while fib_req=1 -> fib_req, out_valid, and busy go 0 asynchronously; next in_n=3 -> out_result=2.
